// File: rtl/eth_preamble_sfd_rx.sv
// GMII receive preamble/SFD detector: locks onto 0x55 runs, flags the SFD.
// Ports: mac_gmii_rx_* in; preamble_sfd_valid, frame_active, frame_cnt, preamble_err_cnt out.
module eth_preamble_sfd_rx #(
  parameter int PRE_MIN = 6,
  parameter int PRE_MAX = 7
) (
  input  logic        mac_gmii_rx_clk,
  input  logic        mac_gmii_rx_rstn,
  input  logic [7:0]  mac_gmii_rxd,
  input  logic        mac_gmii_rx_dv,
  input  logic        mac_gmii_rx_er,
  output logic        preamble_sfd_valid,
  output logic        frame_active,
  output logic [15:0] frame_cnt,
  output logic [15:0] preamble_err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    FRAME,
    DROP
  } state_t;

  localparam logic [3:0] MIN4 = 4'(PRE_MIN);
  localparam logic [3:0] MAX4 = 4'(PRE_MAX);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       good;
  logic       is_pre;
  logic       is_sfd;
  logic       sfd_ok;
  logic       frame_inc;
  logic       err_inc;

  assign good   = mac_gmii_rx_dv & ~mac_gmii_rx_er;
  assign is_pre = good && (mac_gmii_rxd == 8'h55);
  assign is_sfd = good && (mac_gmii_rxd == 8'hD5);
  assign sfd_ok = is_sfd && (cnt >= MIN4);

  always_ff @(posedge mac_gmii_rx_clk or negedge mac_gmii_rx_rstn) begin
    if (!mac_gmii_rx_rstn) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      frame_active <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      frame_active <= (state_nx == FRAME);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (is_pre) begin
          state_nx = PREAMBLE;
          cnt_nx   = 4'd1;
        end else if (mac_gmii_rx_dv) begin
          state_nx = DROP;
        end
      end
      PREAMBLE: begin
        if (!mac_gmii_rx_dv) begin
          state_nx = IDLE;
        end else if (is_pre) begin
          // one more 0x55 than PRE_MAX is a malformed preamble
          if (cnt >= MAX4) state_nx = DROP;
          else cnt_nx = cnt + 4'd1;
        end else if (sfd_ok) begin
          state_nx = FRAME;
        end else begin
          state_nx = DROP;
        end
      end
      FRAME, DROP: begin
        if (!mac_gmii_rx_dv) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // counter only carries meaning while collecting a preamble
    if (state_nx != PREAMBLE) cnt_nx = 4'd0;
  end

  always_comb begin
    preamble_sfd_valid = 1'b0;
    frame_inc          = 1'b0;
    err_inc            = 1'b0;
    unique case (state)
      IDLE: begin
        err_inc = mac_gmii_rx_dv && !is_pre;
      end
      PREAMBLE: begin
        preamble_sfd_valid = mac_gmii_rx_dv && sfd_ok;
        frame_inc          = mac_gmii_rx_dv && sfd_ok;
        err_inc            = (state_nx == IDLE) || (state_nx == DROP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge mac_gmii_rx_clk or negedge mac_gmii_rx_rstn) begin
    if (!mac_gmii_rx_rstn) begin
      frame_cnt        <= 16'd0;
      preamble_err_cnt <= 16'd0;
    end else begin
      if (frame_inc && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (err_inc && preamble_err_cnt != 16'hFFFF)
        preamble_err_cnt <= preamble_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_preamble_sfd_rx.sv
// Directed bench for eth_preamble_sfd_rx: table of preamble cases
// plus hand sequences for back-to-back, async reset and saturation.
module tb_eth_preamble_sfd_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic        sfd_valid;
  logic        frame_active;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  eth_preamble_sfd_rx dut (
    .mac_gmii_rx_clk    (clk),
    .mac_gmii_rx_rstn   (rst_n),
    .mac_gmii_rxd       (rxd),
    .mac_gmii_rx_dv     (dv),
    .mac_gmii_rx_er     (er),
    .preamble_sfd_valid (sfd_valid),
    .frame_active       (frame_active),
    .frame_cnt          (frame_cnt),
    .preamble_err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         n_pre;
    logic [7:0] sfd;
    int         er_pos;
    int         drop_at;
    bit         pat;
    int         e_pulses;
    int         e_pidx;
    int         e_fa;
    int         e_fc;
    int         e_err;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int pulses;
  int pidx;
  int idx;
  int fa_cnt;

  function automatic void chk(string n, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endfunction

  task automatic clr();
    pulses = 0;
    pidx   = -1;
    idx    = 0;
    fa_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic e,
                       input logic [7:0] d);
    @(negedge clk);
    dv  = v;
    er  = e;
    rxd = d;
    #1;
    if (sfd_valid) begin
      pulses++;
      if (pidx < 0) pidx = idx;
    end
    if (frame_active && v) fa_cnt++;
    idx++;
  endtask

  function automatic logic [7:0] pay(input bit pat, input int i);
    if (pat && i < 7) return 8'h55;
    if (pat && i == 7) return 8'hD5;
    return 8'(8'h10 + i);
  endfunction

  task automatic legal(input int plen);
    for (int i = 0; i < 7; i++) drive(1, 0, 8'h55);
    drive(1, 0, 8'hD5);
    for (int i = 0; i < plen; i++) drive(1, 0, pay(0, i));
  endtask

  vec_t tbl[9];

  initial begin
    int fc0;
    int er0;
    bit dropped;

    tbl[0] = '{"pre7",    7, 8'hD5, -1, -1, 0, 1, 7, 60, 1, 0};
    tbl[1] = '{"pre6",    6, 8'hD5, -1, -1, 0, 1, 6, 60, 1, 0};
    tbl[2] = '{"pre5",    5, 8'hD5, -1, -1, 1, 0, -1, 0, 0, 1};
    tbl[3] = '{"pre8",    8, 8'hD5, -1, -1, 0, 0, -1, 0, 0, 1};
    tbl[4] = '{"er3",     7, 8'hD5,  2, -1, 0, 0, -1, 0, 0, 1};
    tbl[5] = '{"dvdrop4", 7, 8'hD5, -1,  4, 0, 0, -1, 0, 0, 1};
    tbl[6] = '{"badsfd",  7, 8'hAA, -1, -1, 0, 0, -1, 0, 0, 1};
    tbl[7] = '{"nopre",   0, 8'hD5, -1, -1, 0, 0, -1, 0, 0, 1};
    tbl[8] = '{"paypat",  7, 8'hD5, -1, -1, 1, 1, 7, 60, 1, 0};

    #12;
    chk("rst_pulse", int'(sfd_valid), 0);
    chk("rst_fa", int'(frame_active), 0);
    chk("rst_fc", int'(frame_cnt), 0);
    chk("rst_err", int'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 8'h00);

    for (int r = 0; r < 9; r++) begin
      fc0 = int'(frame_cnt);
      er0 = int'(err_cnt);
      clr();
      dropped = 0;
      for (int i = 0; i < tbl[r].n_pre; i++) begin
        if (i == tbl[r].drop_at) begin
          dropped = 1;
          break;
        end
        drive(1, i == tbl[r].er_pos, 8'h55);
      end
      if (!dropped) begin
        drive(1, 0, tbl[r].sfd);
        for (int i = 0; i < 60; i++) drive(1, 0, pay(tbl[r].pat, i));
      end
      drive(0, 0, 8'h00);
      drive(0, 0, 8'h00);
      chk({tbl[r].name, "_pulses"}, pulses, tbl[r].e_pulses);
      chk({tbl[r].name, "_pidx"}, pidx, tbl[r].e_pidx);
      chk({tbl[r].name, "_fa"}, fa_cnt, tbl[r].e_fa);
      chk({tbl[r].name, "_fc"}, int'(frame_cnt) - fc0, tbl[r].e_fc);
      chk({tbl[r].name, "_err"}, int'(err_cnt) - er0, tbl[r].e_err);
      chk({tbl[r].name, "_fa_off"}, int'(frame_active), 0);
    end

    // back-to-back frames, single idle cycle between
    fc0 = int'(frame_cnt);
    clr();
    legal(10);
    drive(0, 0, 8'h00);
    legal(10);
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_fc", int'(frame_cnt) - fc0, 2);

    // async reset mid-payload
    clr();
    legal(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pulse", int'(sfd_valid), 0);
    chk("arst_fa", int'(frame_active), 0);
    chk("arst_fc", int'(frame_cnt), 0);
    chk("arst_err", int'(err_cnt), 0);
    drive(1, 0, 8'h12);
    rst_n = 1'b1;
    clr();
    drive(1, 0, 8'h13);
    for (int i = 0; i < 7; i++) drive(1, 0, 8'h55);
    drive(1, 0, 8'hD5);
    drive(1, 0, 8'h14);
    drive(0, 0, 8'h00);
    chk("midrel_pulses", pulses, 0);
    chk("midrel_err", int'(err_cnt), 1);
    clr();
    legal(4);
    drive(0, 0, 8'h00);
    chk("midrel_legal_pulses", pulses, 1);
    chk("midrel_legal_fc", int'(frame_cnt), 1);

    // frame counter saturation
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    clr();
    legal(4);
    drive(0, 0, 8'h00);
    chk("sat_pulses", pulses, 1);
    chk("sat_fc", int'(frame_cnt), 65535);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
